ram_sp_be: RTL

- Parametrised successor to the team's 1Kx8 single-port synchronous RAM: configurable width and depth, per-byte write enables, and a 1- or 2-cycle read pipeline with a read-valid strobe.
- Built-in memory-clear state machine zeroes the array after reset, with a busy flag.
- Request errors are flagged: wr and rd asserted together, access while busy, address out of range.
- Sits as generic on-chip storage behind simple cs/wr/rd masters.

---
 rtl/ram_sp_be.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/ram_sp_be.sv
`default_nettype none
// ============================================================================
// Module   : ram_sp_be
// Purpose  : Single-port synchronous RAM with configurable width and depth.
//            Supports per-byte write enables and a 1- or 2-cycle pipelined
//            read with a read-valid strobe. After reset, a built-in clear
//            state machine can zero the array while busy is high. Rejected
//            requests raise a one-cycle err pulse.
// Ports    : clk      - system clock, rising edge
//            rst_n    - asynchronous active-low reset
//            cs       - chip select
//            wr / rd  - write / read request
//            address  - word address
//            data_in  - write data
//            be       - byte enables, bit i covers data_in[8i+7:8i]
//            data_out - registered read data, holds between reads
//            rd_valid - one-cycle pulse per completed read
//            busy     - memory clear in progress, requests rejected
//            err      - one-cycle pulse on a rejected request
// Revision : 1.0 - initial release
// ============================================================================
module ram_sp_be #(
    parameter int DATA_WIDTH     = 8,     // multiple of 8
    parameter int ADDR_WIDTH     = 10,
    parameter int DEPTH          = 1024,  // at most 2**ADDR_WIDTH
    parameter int RD_LATENCY     = 1,     // 1 or 2
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cs,
    input  logic                    wr,
    input  logic                    rd,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [DATA_WIDTH/8-1:0] be,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    rd_valid,
    output logic                    busy,
    output logic                    err
);

    localparam int c_NUM_LANES = DATA_WIDTH / 8;
    // Width needed to index the physical array; upper address bits only
    // take part in the range check.
    localparam int c_IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DEPTH - 1);

    localparam logic [0:0] c_ST_CLEAR = 1'b0;
    localparam logic [0:0] c_ST_IDLE  = 1'b1;
    localparam logic [0:0] c_ST_RESET = CLEAR_ON_RESET ? c_ST_CLEAR : c_ST_IDLE;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [c_IDX_W-1:0]    r_clr_cnt;
    logic [c_IDX_W-1:0]    w_clr_cnt_nxt;
    logic                  w_clr_we;

    logic [c_IDX_W-1:0]    w_idx;
    logic                  w_in_range;
    logic                  w_busy;
    logic                  w_req;
    logic                  w_conflict;
    logic                  w_wr_en;
    logic                  w_rd_acc;
    logic                  w_err;
    logic [DATA_WIDTH-1:0] w_rd_word;

    logic                  r_err;
    logic                  r_rd_valid;
    logic [DATA_WIDTH-1:0] r_data_out;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign w_idx      = address[c_IDX_W-1:0];
    assign w_in_range = (32'(address) < 32'(DEPTH));
    assign w_busy     = (r_state == c_ST_CLEAR);
    assign w_req      = cs & (wr | rd);
    assign w_conflict = cs & wr & rd;
    assign w_wr_en    = cs & wr & ~rd & ~w_busy & w_in_range;
    // Out-of-range reads are still accepted so the requester sees a
    // rd_valid (with zero data) and never waits on a missing response.
    assign w_rd_acc   = cs & rd & ~wr & ~w_busy;
    assign w_err      = w_req & (w_busy | w_conflict | ~w_in_range);
    assign w_rd_word  = w_in_range ? r_mem[w_idx] : '0;

    // ------------------------------------------------------------------
    // Clear state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_ST_RESET;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_clr_we      = 1'b0;
        if (r_state == c_ST_CLEAR) begin
            w_clr_we = 1'b1;
            if (r_clr_cnt == c_LAST_IDX) begin
                w_state_nxt   = c_ST_IDLE;
                w_clr_cnt_nxt = '0;
            end else begin
                w_clr_cnt_nxt = r_clr_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Array write port. Held off while rst_n is low so that reset alone
    // never modifies stored contents.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (w_clr_we) begin
                r_mem[r_clr_cnt] <= '0;
            end else if (w_wr_en) begin
                for (int i = 0; i < c_NUM_LANES; i++) begin
                    if (be[i]) begin
                        r_mem[w_idx][8*i +: 8] <= data_in[8*i +: 8];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Error pulse: registered off the edge that samples the request.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err;
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline. data_out only loads on a completing read so it holds
    // its last value between reads.
    // ------------------------------------------------------------------
    generate
        if (RD_LATENCY == 2) begin : g_rd_lat2
            logic                  r_p1_valid;
            logic [DATA_WIDTH-1:0] r_p1_data;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_p1_valid <= 1'b0;
                    r_p1_data  <= '0;
                    r_rd_valid <= 1'b0;
                    r_data_out <= '0;
                end else begin
                    r_p1_valid <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_p1_data <= w_rd_word;
                    end
                    r_rd_valid <= r_p1_valid;
                    if (r_p1_valid) begin
                        r_data_out <= r_p1_data;
                    end
                end
            end
        end else begin : g_rd_lat1
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rd_valid <= 1'b0;
                    r_data_out <= '0;
                end else begin
                    r_rd_valid <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_data_out <= w_rd_word;
                    end
                end
            end
        end
    endgenerate

    assign data_out = r_data_out;
    assign rd_valid = r_rd_valid;
    assign busy     = w_busy;
    assign err      = r_err;

endmodule
`default_nettype wire
